cache_refill: RTL and testbench

Miss-handling controller for the CPU's 2-way data cache. It watches each CPU read lookup and, on a miss, freezes the pipeline. It then fetches the missing word from main memory over a request/acknowledge handshake and writes it back into the cache through a single-cycle fill port. It sits between the cache (which supplies `hit` and accepts fills) and the main-memory interface.

---
 rtl/cache_refill.sv | 115 +++++++++++
 tb/tb_cache_refill.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// Miss-handling controller for the 2-way data cache: on a read miss it stalls the
// pipeline, fetches the word from main memory and writes it back through the fill port.
module cache_refill #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              hit,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       miss_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] miss_addr_reg, miss_addr_next;
  logic [DATA_W-1:0] fill_buf_reg, fill_buf_next;
  logic [7:0]        wait_reg, wait_next;
  logic              err_reg, err_next;
  logic [15:0]       miss_cnt_reg, miss_cnt_next;
  logic              timeout;

  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    fill_buf_next  = fill_buf_reg;
    wait_next      = wait_reg;
    miss_cnt_next  = miss_cnt_reg;
    timeout        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req && !hit) begin
          miss_addr_next = addr;
          wait_next      = 8'd0;
          state_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        // An ack in the final wait cycle still counts as a successful fetch.
        if (mem_ack) begin
          fill_buf_next = mem_rdata;
          if (miss_cnt_reg != 16'hFFFF) begin
            miss_cnt_next = miss_cnt_reg + 16'd1;
          end
          state_next = S_FILL;
        end else if (wait_reg == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      S_FILL:   state_next = S_SETTLE;
      S_SETTLE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // A timeout in the same cycle as a clear request leaves the flag set.
  always_comb begin
    err_next = err_reg;
    if (timeout) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      miss_addr_reg <= '0;
      fill_buf_reg  <= '0;
      wait_reg      <= 8'd0;
      err_reg       <= 1'b0;
      miss_cnt_reg  <= 16'd0;
    end else begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
      fill_buf_reg  <= fill_buf_next;
      wait_reg      <= wait_next;
      err_reg       <= err_next;
      miss_cnt_reg  <= miss_cnt_next;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign stall     = (state_reg == S_IDLE) ? (req & ~hit) : 1'b1;
  assign mem_req   = (state_reg == S_FETCH);
  assign fill_we   = (state_reg == S_FILL);
  assign mem_addr  = miss_addr_reg;
  assign fill_addr = miss_addr_reg;
  assign fill_data = fill_buf_reg;
  assign err       = err_reg;
  assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: reset, hit path, miss latency, timeout,
// back-to-back misses and edge cases, checked with immediate assertions.
module tb_cache_refill;

  logic        clk;
  logic        rst;
  logic        req;
  logic [7:0]  addr;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        fill_we;
  logic [7:0]  fill_addr;
  logic [15:0] fill_data;
  logic        err;
  logic        err_clr;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  int fill_cnt  = 0;
  int mreq_cnt  = 0;
  int stall_cnt = 0;
  int base_fill, base_mreq, base_stall;

  cache_refill #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .hit(hit), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .err(err), .err_clr(err_clr), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (fill_we) fill_cnt  <= fill_cnt + 1;
    if (mem_req) mreq_cnt  <= mreq_cnt + 1;
    if (stall)   stall_cnt <= stall_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_fill  = fill_cnt;
    base_mreq  = mreq_cnt;
    base_stall = stall_cnt;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; addr = 8'h00; hit = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000; err_clr = 1'b0;

    // 1. Reset values and reset mid-FETCH
    tick(); tick();
    rst = 1'b1;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_fill_we", 32'(fill_we), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_fill_data", 32'(fill_data), 0);
    tick();
    snap();
    req = 1'b1; hit = 1'b0; addr = 8'h33;
    #2 chk("rst_miss_stall", 32'(stall), 1);
    tick();
    #2 chk("rst_fetch_req", 32'(mem_req), 1);
    chk("rst_fetch_addr", 32'(mem_addr), 32'h33);
    tick();
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 0);
    chk("rst_async_mem_addr", 32'(mem_addr), 0);
    chk("rst_async_stall", 32'(stall), 0);
    tick();
    rst = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    tick(); tick();
    chk("rst_no_fill", fill_cnt - base_fill, 0);
    chk("rst_cnt_zero", 32'(miss_cnt), 0);
    chk("rst_err_zero", 32'(err), 0);

    // 2. Hit path
    snap();
    req = 1'b1; hit = 1'b1; addr = 8'h12;
    for (int i = 0; i < 10; i++) tick();
    chk("hit_stall_cycles", stall_cnt - base_stall, 0);
    chk("hit_mem_req_cycles", mreq_cnt - base_mreq, 0);
    chk("hit_fill_cycles", fill_cnt - base_fill, 0);
    chk("hit_miss_cnt", 32'(miss_cnt), 0);

    // 3. Single miss acked in the 3rd FETCH cycle
    req = 1'b1; hit = 1'b0; addr = 8'h5A;
    snap();
    tick();
    #2 chk("m1_mem_addr_c1", 32'(mem_addr), 32'h5A);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #2 chk("m1_mem_req_c3", 32'(mem_req), 1);
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    #2 chk("m1_fill_we", 32'(fill_we), 1);
    chk("m1_fill_addr", 32'(fill_addr), 32'h5A);
    chk("m1_fill_data", 32'(fill_data), 32'hBEEF);
    tick();
    hit = 1'b1;
    #2 chk("m1_settle_stall", 32'(stall), 1);
    tick();
    #2 chk("m1_idle_stall", 32'(stall), 0);
    tick();
    req = 1'b0;
    chk("m1_mem_req_cycles", mreq_cnt - base_mreq, 3);
    chk("m1_fill_cycles", fill_cnt - base_fill, 1);
    chk("m1_stall_cycles", stall_cnt - base_stall, 6);
    chk("m1_miss_cnt", 32'(miss_cnt), 1);

    // 4. Timeout, set-wins-over-clear, then clear
    req = 1'b1; hit = 1'b0; addr = 8'h77;
    snap();
    for (int i = 0; i < 15; i++) tick();
    #2 chk("to_req_c15", 32'(mem_req), 1);
    chk("to_err_c15", 32'(err), 0);
    tick();
    req = 1'b0;
    #2 chk("to_err_set", 32'(err), 1);
    chk("to_mem_req_off", 32'(mem_req), 0);
    chk("to_stall_off", 32'(stall), 0);
    tick();
    chk("to_mem_req_cycles", mreq_cnt - base_mreq, 15);
    chk("to_no_fill", fill_cnt - base_fill, 0);
    chk("to_miss_cnt", 32'(miss_cnt), 1);
    req = 1'b1; addr = 8'h88;
    for (int i = 0; i < 15; i++) tick();
    err_clr = 1'b1;
    #2 chk("to2_mem_addr", 32'(mem_addr), 32'h88);
    tick();
    err_clr = 1'b0; req = 1'b0;
    #2 chk("to2_set_wins", 32'(err), 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #2 chk("to_err_cleared", 32'(err), 0);

    // 5. Back-to-back misses
    snap();
    req = 1'b1; hit = 1'b0; addr = 8'h10;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    #2 chk("b2b_addr1", 32'(mem_addr), 32'h10);
    tick();
    mem_ack = 1'b0;
    #2 chk("b2b_fill1_we", 32'(fill_we), 1);
    chk("b2b_fill1_addr", 32'(fill_addr), 32'h10);
    chk("b2b_fill1_data", 32'(fill_data), 32'h1111);
    tick();
    tick();
    addr = 8'h24;
    #2 chk("b2b_idle_stall", 32'(stall), 1);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    #2 chk("b2b_addr2", 32'(mem_addr), 32'h24);
    tick();
    mem_ack = 1'b0; req = 1'b0;
    #2 chk("b2b_fill2_we", 32'(fill_we), 1);
    chk("b2b_fill2_addr", 32'(fill_addr), 32'h24);
    chk("b2b_fill2_data", 32'(fill_data), 32'h2222);
    tick(); tick();
    chk("b2b_fill_cycles", fill_cnt - base_fill, 2);
    chk("b2b_miss_cnt", 32'(miss_cnt), 3);

    // 6a. Ack on the 15th FETCH cycle, then stray acks in SETTLE and IDLE
    snap();
    req = 1'b1; hit = 1'b0; addr = 8'h42;
    for (int i = 0; i < 15; i++) tick();
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0; req = 1'b0;
    #2 chk("last_fill_we", 32'(fill_we), 1);
    chk("last_fill_data", 32'(fill_data), 32'hCAFE);
    chk("last_no_err", 32'(err), 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h0BAD;
    tick();
    tick();
    mem_ack = 1'b0;
    #2 chk("stray_mem_req", 32'(mem_req), 0);
    chk("stray_fill_data", 32'(fill_data), 32'hCAFE);
    tick();
    chk("stray_fill_cycles", fill_cnt - base_fill, 1);
    chk("last_miss_cnt", 32'(miss_cnt), 4);
    chk("last_err", 32'(err), 0);

    // 6b. Saturating miss counter
    force dut.miss_cnt_reg = 16'hFFFF;
    #1 release dut.miss_cnt_reg;
    #1 chk("sat_preload", 32'(miss_cnt), 32'hFFFF);
    tick();
    req = 1'b1; hit = 1'b0; addr = 8'h99;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0; req = 1'b0;
    tick(); tick();
    chk("sat_miss_cnt", 32'(miss_cnt), 32'hFFFF);
    chk("sat_fill_data", 32'(fill_data), 32'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
